bram_1rw_tiled: RTL

Parametrised single-port (1RW) memory that tiles one fixed-size macro (MACRO_DEPTH x MACRO_WIDTH) into an arbitrary DEPTH x DATA_WIDTH array. It adds a valid/ready request port, a fixed-latency read response with an optional output register, a post-reset zero-initialisation sequencer, and out-of-range address detection. It sits between cache/buffer controllers and the hard SRAM macros, and replaces per-size macro selection with a single generic array.

---
 rtl/bram_pkg.sv | 22 ++
 rtl/bram_1rw_tiled_if.sv | 31 +++
 rtl/bram_1rw_tile.sv | 46 ++++
 rtl/bram_1rw_tiled.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared definitions for the tiled 1RW memory.
//   ceil_div / clog2 : constant helpers for tiling geometry
//   bram_state_e     : sequencer states (zero-init, normal operation)
package bram_pkg;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } bram_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bram_1rw_tiled_if.sv
// Request/response bundle of the tiled memory.
//   req_*      : valid/ready request (we, addr, per-bit write mask, data)
//   rsp_*      : fixed-latency read response, no backpressure
//   init_busy  : zero-init sequencer running
//   err_addr   : sticky out-of-range flag
// master = requester, slave = memory.
interface bram_1rw_tiled_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_bw;
  logic [DATA_WIDTH-1:0] req_din;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_dout;
  logic                  init_busy;
  logic                  err_addr;

  modport master (
    output req_valid, req_we, req_addr, req_bw, req_din,
    input  req_ready, rsp_valid, rsp_dout, init_busy, err_addr
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_bw, req_din,
    output req_ready, rsp_valid, rsp_dout, init_busy, err_addr
  );
endinterface

// File: rtl/bram_1rw_tile.sv
// One MACRO_DEPTH x MACRO_WIDTH single-port macro, 1-cycle read latency.
//   clk       : clock
//   ce_in     : access enable
//   we_in     : 1 = write, 0 = read
//   w_mask_in : per-bit write enable
//   addr_in   : word address
//   wd_in     : write data
//   rd_out    : read data, held between reads
// With BRAM_USE_FAKERAM defined the hard macro is used; the macro name must
// match the tile geometry. Otherwise a behavioural model stands in.
module bram_1rw_tile #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             ce_in,
  input  logic             we_in,
  input  logic [WIDTH-1:0] w_mask_in,
  input  logic [AW-1:0]    addr_in,
  input  logic [WIDTH-1:0] wd_in,
  output logic [WIDTH-1:0] rd_out
);

`ifdef BRAM_USE_FAKERAM
  fakeram65_512x32 u_macro (
    .clk       (clk),
    .ce_in     (ce_in),
    .we_in     (we_in),
    .w_mask_in (w_mask_in),
    .addr_in   (addr_in),
    .wd_in     (wd_in),
    .rd_out    (rd_out)
  );
`else
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce_in) begin
      if (we_in) mem[addr_in] <= (mem[addr_in] & ~w_mask_in) | (wd_in & w_mask_in);
      else       rd_out       <= mem[addr_in];
    end
  end
`endif

endmodule

// File: rtl/bram_1rw_tiled.sv
// Generic DEPTH x DATA_WIDTH single-port memory built from ROWS x COLS tiles.
//   memclk : clock
//   reset  : async active-high reset
//   bus    : request/response port (slave side)
// Reads return after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
// Out-of-range requests are accepted, touch no tile, read back zero and set
// the sticky err_addr flag.
module bram_1rw_tiled
  import bram_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int DATA_WIDTH  = 64,
  parameter int MACRO_DEPTH = 512,
  parameter int MACRO_WIDTH = 32,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int OUT_REG     = 1,
  parameter int INIT_ZERO   = 1
) (
  input  logic             memclk,
  input  logic             reset,
  bram_1rw_tiled_if.slave  bus
);

  localparam int COLS   = ceil_div(DATA_WIDTH, MACRO_WIDTH);
  localparam int ROWS   = ceil_div(DEPTH, MACRO_DEPTH);
  localparam int MAW    = clog2(MACRO_DEPTH);
  localparam int PW     = COLS * MACRO_WIDTH;
  localparam int RW     = (ROWS > 1) ? clog2(ROWS) : 1;
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  // sequencer
  logic [0:0]     state;
  logic [MAW-1:0] init_i;
  logic           init_busy;

  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      state  <= (INIT_ZERO != 0) ? S_INIT : S_RUN;
      init_i <= '0;
    end else if (state == S_INIT) begin
      init_i <= init_i + 1'b1;
      if (init_i == MAW'(MACRO_DEPTH - 1)) state <= S_RUN;
    end
  end

  assign init_busy     = (state == S_INIT);
  assign bus.init_busy = init_busy;
  assign bus.req_ready = (state == S_RUN);

  // decode
  logic        acc, rd_acc, oor;
  logic [31:0] addr32, row32;

  assign acc    = bus.req_valid & bus.req_ready;
  assign rd_acc = acc & ~bus.req_we;
  assign addr32 = 32'(bus.req_addr);
  assign oor    = addr32 >= 32'(DEPTH);
  assign row32  = addr32 >> MAW;

  // tile inputs are shared by every tile; only ce is per row.
  // Init overrides with a full-mask zero write to init_i everywhere.
  logic           t_we;
  logic [MAW-1:0] t_addr;
  logic [PW-1:0]  t_mask, t_wd;
  logic [ROWS-1:0] row_ce;
  logic [ROWS-1:0][PW-1:0] rd_all;

  assign t_we   = init_busy | bus.req_we;
  assign t_addr = init_busy ? init_i : bus.req_addr[MAW-1:0];
  assign t_mask = init_busy ? '1 : PW'(bus.req_bw);   // padding bits masked off
  assign t_wd   = init_busy ? '0 : PW'(bus.req_din);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign row_ce[r] = init_busy | (acc & ~oor & (row32 == 32'(r)));
    for (genvar c = 0; c < COLS; c++) begin : g_col
      bram_1rw_tile #(
        .DEPTH (MACRO_DEPTH),
        .WIDTH (MACRO_WIDTH),
        .AW    (MAW)
      ) u_tile (
        .clk       (memclk),
        .ce_in     (row_ce[r]),
        .we_in     (t_we),
        .w_mask_in (t_mask[c*MACRO_WIDTH +: MACRO_WIDTH]),
        .addr_in   (t_addr),
        .wd_in     (t_wd[c*MACRO_WIDTH +: MACRO_WIDTH]),
        .rd_out    (rd_all[r][c*MACRO_WIDTH +: MACRO_WIDTH])
      );
    end
  end

  if (PW > DATA_WIDTH) begin : g_pad
    logic [ROWS-1:0] unused_pad;
    for (genvar r = 0; r < ROWS; r++) begin : g_pr
      assign unused_pad[r] = ^rd_all[r][PW-1:DATA_WIDTH];
    end
  end

  // read pipeline: row select travels with the macro access
  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;
  logic [RW-1:0]   row_q;
  logic            oor_q;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign vld_pipe = {vld_q, rd_acc};

  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      row_q <= '0;
      oor_q <= 1'b0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (rd_acc) begin
        row_q <= row32[RW-1:0];
        oor_q <= oor;
      end
    end
  end

  // zero unless a valid in-range read is leaving the macros
  always_comb begin
    rd_mux = '0;
    if (vld_pipe[1] & ~oor_q) begin
      for (int r = 0; r < ROWS; r++)
        if (row_q == RW'(r)) rd_mux = rd_all[r][DATA_WIDTH-1:0];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] rsp_q;
    always_ff @(posedge memclk or posedge reset) begin
      if (reset)            rsp_q <= '0;
      else if (vld_pipe[1]) rsp_q <= rd_mux;
    end
    assign bus.rsp_dout = rsp_q;
  end else begin : g_ocomb
    assign bus.rsp_dout = rd_mux;
  end

  assign bus.rsp_valid = vld_pipe[STAGES];

  logic err_q;
  always_ff @(posedge memclk or posedge reset) begin
    if (reset)          err_q <= 1'b0;
    else if (acc & oor) err_q <= 1'b1;
  end
  assign bus.err_addr = err_q;

endmodule
